// File: rtl/vertex_project.sv
// vertex_project: multiplies (x, y, z, 1) by a latched 4x4 Q8.8 matrix, then divides x/y/z by w.
// A single multiplier is reused across the 12 MAC steps; one restoring divider serves all three divides.
module vertex_project #(
    parameter int unsigned DIV_BITS = 24
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [15:0][15:0] matrix,
    input  logic [15:0]       in_x,
    input  logic [15:0]       in_y,
    input  logic [15:0]       in_z,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [15:0]       out_x,
    output logic [15:0]       out_y,
    output logic [15:0]       out_z,
    output logic [15:0]       out_w,
    output logic              clipped,
    output logic              sat,
    output logic              out_valid,
    input  logic              out_ready
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] MAC   = 3'd1;
    localparam logic [2:0] CHECK = 3'd2;
    localparam logic [2:0] DIV   = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;
    localparam logic [5:0] LAST_BIT = 6'(DIV_BITS - 1);

    logic [2:0]          state;
    logic [15:0][15:0]   m_reg;
    logic [2:0][15:0]    vtx;
    logic [2:0][15:0]    clip_n;
    logic [1:0]          row, col, comp;
    logic signed [31:0]  acc;
    logic [5:0]          bit_cnt;
    logic [15:0]         rem;
    logic [DIV_BITS-1:0] dq;

    logic [15:0]         m_el, m_off, v_el, clip_val;
    logic signed [31:0]  prod, acc_next;
    logic                clip_sat;

    always_comb begin
        m_el  = m_reg[{row, col}];
        m_off = m_reg[{row, 2'b11}];
        case (col)
            2'd0:    v_el = vtx[0];
            2'd1:    v_el = vtx[1];
            default: v_el = vtx[2];
        endcase
        prod     = $signed({{16{m_el[15]}}, m_el}) * $signed({{16{v_el[15]}}, v_el});
        acc_next = ((col == 2'd0) ? $signed({{8{m_off[15]}}, m_off, 8'h00}) : acc) + prod;
        clip_sat = 1'b1;
        if (acc_next > 32'sh007F_FFFF)
            clip_val = 16'h7FFF;
        else if (acc_next < 32'shFF80_0000)
            clip_val = 16'h8000;
        else begin
            clip_val = acc_next[23:8];
            clip_sat = 1'b0;
        end
    end

    // Restoring divider step: dividend bits shift out of dq's MSB while quotient bits shift in at its LSB.
    logic [16:0]         rem_sh, divisor;
    logic                ge, q_big;
    logic [15:0]         rem_next, num, q_res;
    logic [DIV_BITS-1:0] dq_next;

    always_comb begin
        divisor  = {1'b0, out_w};
        rem_sh   = {rem, dq[DIV_BITS-1]};
        ge       = (rem_sh >= divisor);
        rem_next = ge ? 16'(rem_sh - divisor) : rem_sh[15:0];
        dq_next  = {dq[DIV_BITS-2:0], ge};
        case (comp)
            2'd0:    num = clip_n[0];
            2'd1:    num = clip_n[1];
            default: num = clip_n[2];
        endcase
        q_big = (32'(dq_next) > 32'h0000_7FFF);
        if (q_big)
            q_res = num[15] ? 16'h8000 : 16'h7FFF;
        else if (num[15])
            q_res = 16'h0000 - dq_next[15:0];
        else
            q_res = dq_next[15:0];
    end

    function automatic logic [DIV_BITS-1:0] dividend_of(input logic [15:0] c);
        logic [15:0] mag;
        mag = c[15] ? 16'h0000 - c : c;
        return DIV_BITS'({mag, 8'h00});
    endfunction

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            m_reg   <= '0;
            vtx     <= '0;
            clip_n  <= '0;
            row     <= '0;
            col     <= '0;
            comp    <= '0;
            acc     <= '0;
            bit_cnt <= '0;
            rem     <= '0;
            dq      <= '0;
            out_x   <= '0;
            out_y   <= '0;
            out_z   <= '0;
            out_w   <= '0;
            clipped <= 1'b0;
            sat     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    m_reg   <= matrix;
                    vtx     <= {in_z, in_y, in_x};
                    row     <= '0;
                    col     <= '0;
                    clipped <= 1'b0;
                    sat     <= 1'b0;
                    state   <= MAC;
                end
                MAC: begin
                    acc <= acc_next;
                    if (col == 2'd2) begin
                        col <= '0;
                        sat <= sat | clip_sat;
                        case (row)
                            2'd0:    clip_n[0] <= clip_val;
                            2'd1:    clip_n[1] <= clip_val;
                            2'd2:    clip_n[2] <= clip_val;
                            default: out_w     <= clip_val;
                        endcase
                        if (row == 2'd3)
                            state <= CHECK;
                        else
                            row <= row + 2'd1;
                    end else begin
                        col <= col + 2'd1;
                    end
                end
                CHECK: begin
                    if (out_w[15] || out_w == '0) begin
                        out_x   <= '0;
                        out_y   <= '0;
                        out_z   <= '0;
                        clipped <= 1'b1;
                        state   <= DONE;
                    end else begin
                        dq      <= dividend_of(clip_n[0]);
                        rem     <= '0;
                        bit_cnt <= '0;
                        comp    <= '0;
                        state   <= DIV;
                    end
                end
                DIV: begin
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt <= '0;
                        rem     <= '0;
                        sat     <= sat | q_big;
                        case (comp)
                            2'd0:    out_x <= q_res;
                            2'd1:    out_y <= q_res;
                            default: out_z <= q_res;
                        endcase
                        if (comp == 2'd2) begin
                            state <= DONE;
                        end else begin
                            comp <= comp + 2'd1;
                            dq   <= dividend_of((comp == 2'd0) ? clip_n[1] : clip_n[2]);
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 6'd1;
                        rem     <= rem_next;
                        dq      <= dq_next;
                    end
                end
                DONE: if (out_ready) begin
                    clipped <= 1'b0;
                    sat     <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vertex_project.sv
// Bench for vertex_project: directed vectors with hand-derived results, then random
// vertices checked against an integer-arithmetic model of the projection and divide.
module tb_vertex_project;
    logic              Clk = 1'b0;
    logic              Reset;
    logic [15:0][15:0] matrix;
    logic [15:0]       in_x, in_y, in_z;
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       out_x, out_y, out_z, out_w;
    logic              clipped, sat, out_valid;
    logic              out_ready;

    int checks = 0;
    int errors = 0;

    vertex_project #(.DIV_BITS(24)) dut (
        .Clk(Clk), .Reset(Reset), .matrix(matrix),
        .in_x(in_x), .in_y(in_y), .in_z(in_z), .in_valid(in_valid), .in_ready(in_ready),
        .out_x(out_x), .out_y(out_y), .out_z(out_z), .out_w(out_w),
        .clipped(clipped), .sat(sat), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    // Reference: clip = M * (x,y,z,1) in 32-bit wrapping integers, floor to Q8.8 with clamp,
    // then NDC = |clip|*256 / w truncated, signed like clip, clamped to 16 bits.
    function automatic void model(input logic [15:0][15:0] m, input logic [15:0] x, y, z,
                                  output logic [15:0] ex, ey, ez, ew, output logic ec, es);
        int v[3];
        int clip[4];
        int acc;
        longint mag;
        logic [15:0] res[3];
        v[0] = int'($signed(x));
        v[1] = int'($signed(y));
        v[2] = int'($signed(z));
        es = 1'b0;
        for (int r = 0; r < 4; r++) begin
            acc = int'($signed(m[r*4+3])) * 256;
            for (int c = 0; c < 3; c++) acc += int'($signed(m[r*4+c])) * v[c];
            if (acc > 8388607) begin
                clip[r] = 32767;
                es = 1'b1;
            end else if (acc < -8388608) begin
                clip[r] = -32768;
                es = 1'b1;
            end else begin
                clip[r] = acc >>> 8;
            end
        end
        ew = 16'(clip[3]);
        ec = (clip[3] <= 0);
        for (int n = 0; n < 3; n++) begin
            if (ec) begin
                res[n] = 16'h0000;
            end else begin
                mag = (longint'(clip[n] < 0 ? -clip[n] : clip[n]) * 256) / longint'(clip[3]);
                if (mag > 32767) begin
                    es = 1'b1;
                    res[n] = (clip[n] < 0) ? 16'h8000 : 16'h7FFF;
                end else begin
                    res[n] = 16'((clip[n] < 0) ? -mag : mag);
                end
            end
        end
        ex = res[0];
        ey = res[1];
        ez = res[2];
    endfunction

    task automatic scramble();
        for (int i = 0; i < 16; i++) matrix[i] = 16'($urandom);
        in_x = 16'($urandom);
        in_y = 16'($urandom);
        in_z = 16'($urandom);
    endtask

    task automatic run_vertex(input logic [15:0][15:0] mat, input logic [15:0] x, y, z,
                              input logic [15:0] ex, ey, ez, ew, input logic ec, es,
                              input bit hold, input string tag);
        int lat;
        int want_lat;
        want_lat = ec ? 13 : 13 + 3 * 24;
        chk({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
        matrix    = mat;
        in_x      = x;
        in_y      = y;
        in_z      = z;
        in_valid  = 1'b1;
        out_ready = !hold;
        tick();
        in_valid = 1'b0;
        scramble();
        lat = 0;
        while (!out_valid && lat < 300) begin
            tick();
            lat++;
        end
        chk({tag, ".latency"}, 32'(lat), 32'(want_lat));
        chk({tag, ".out_x"}, 32'(out_x), 32'(ex));
        chk({tag, ".out_y"}, 32'(out_y), 32'(ey));
        chk({tag, ".out_z"}, 32'(out_z), 32'(ez));
        chk({tag, ".out_w"}, 32'(out_w), 32'(ew));
        chk({tag, ".clipped"}, 32'(clipped), 32'(ec));
        chk({tag, ".sat"}, 32'(sat), 32'(es));
        chk({tag, ".in_ready_busy"}, 32'(in_ready), 32'd0);
        if (hold) begin
            for (int i = 0; i < 10; i++) begin
                tick();
                chk({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
                chk({tag, ".hold_data"}, {out_x, out_w}, {ex, ew});
                chk({tag, ".hold_yz"}, {out_y, out_z}, {ey, ez});
                chk({tag, ".hold_flags"}, {30'd0, clipped, sat}, {30'd0, ec, es});
                chk({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
            end
            out_ready = 1'b1;
        end
        tick();
        chk({tag, ".post_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, ".post_valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".post_flags"}, {30'd0, clipped, sat}, 32'd0);
    endtask

    logic [15:0][15:0] ident, persp, nowm, wone, rmat;
    logic [15:0] rx, ry, rz, ex, ey, ez, ew;
    logic ec, es;
    int seen;

    initial begin
        ident = '0;
        ident[0] = 16'h0100; ident[5] = 16'h0100; ident[10] = 16'h0100; ident[15] = 16'h0100;
        persp = '0;
        persp[0] = 16'h0100; persp[5] = 16'h0100; persp[10] = 16'h0100; persp[14] = 16'h0100;
        nowm = ident;
        nowm[15] = 16'h0000;
        wone = ident;
        wone[15] = 16'h0001;

        Reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        matrix = '0; in_x = '0; in_y = '0; in_z = '0;
        tick();
        tick();
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.data", {out_x, out_w}, 32'd0);
        chk("rst.flags", {30'd0, clipped, sat}, 32'd0);
        Reset = 1'b0;
        tick();
        chk("rst.in_ready", 32'(in_ready), 32'd1);

        run_vertex(ident, 16'h0100, 16'h0200, 16'h0300,
                   16'h0100, 16'h0200, 16'h0300, 16'h0100, 1'b0, 1'b0, 1'b0, "ident");
        run_vertex(persp, 16'h0100, 16'hFF00, 16'h0200,
                   16'h0080, 16'hFF80, 16'h0100, 16'h0200, 1'b0, 1'b0, 1'b0, "persp");
        run_vertex(nowm, 16'h0100, 16'h0200, 16'h0300,
                   16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, "clip_w0");
        run_vertex(wone, 16'h0100, 16'h0000, 16'h0000,
                   16'h7FFF, 16'h0000, 16'h0000, 16'h0001, 1'b0, 1'b1, 1'b0, "sat_pos");
        run_vertex(wone, 16'hFF00, 16'h0000, 16'h0000,
                   16'h8000, 16'h0000, 16'h0000, 16'h0001, 1'b0, 1'b1, 1'b0, "sat_neg");
        run_vertex(ident, 16'h0100, 16'h0200, 16'h0300,
                   16'h0100, 16'h0200, 16'h0300, 16'h0100, 1'b0, 1'b0, 1'b1, "bp_hold");
        run_vertex(persp, 16'h0300, 16'h0080, 16'h0400,
                   16'h00C0, 16'h0020, 16'h0100, 16'h0400, 1'b0, 1'b0, 1'b0, "bp_next");

        // Reset asserted between edges while the divider is busy.
        matrix = ident; in_x = 16'h0100; in_y = 16'h0200; in_z = 16'h0300;
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        scramble();
        repeat (39) tick();
        #2 Reset = 1'b1;
        #1;
        chk("midrst.out_valid", 32'(out_valid), 32'd0);
        chk("midrst.xy", {out_x, out_y}, 32'd0);
        chk("midrst.zw", {out_z, out_w}, 32'd0);
        chk("midrst.flags", {30'd0, clipped, sat}, 32'd0);
        tick();
        Reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (out_valid) seen++;
        end
        chk("midrst.no_output", 32'(seen), 32'd0);
        run_vertex(persp, 16'h0100, 16'hFF00, 16'h0200,
                   16'h0080, 16'hFF80, 16'h0100, 16'h0200, 1'b0, 1'b0, 1'b0, "after_rst");

        for (int t = 0; t < 14; t++) begin
            for (int i = 0; i < 16; i++) begin
                if (t < 10) rmat[i] = 16'($urandom_range(0, 1023)) - 16'd512;
                else        rmat[i] = 16'($urandom);
            end
            if (t < 8) rmat[15] = 16'($urandom_range(64, 1023));
            rx = (t < 10) ? 16'($urandom_range(0, 4095)) - 16'd2048 : 16'($urandom);
            ry = (t < 10) ? 16'($urandom_range(0, 4095)) - 16'd2048 : 16'($urandom);
            rz = (t < 10) ? 16'($urandom_range(0, 4095)) - 16'd2048 : 16'($urandom);
            model(rmat, rx, ry, rz, ex, ey, ez, ew, ec, es);
            run_vertex(rmat, rx, ry, rz, ex, ey, ez, ew, ec, es, (t == 3), $sformatf("rand%0d", t));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
